// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - EX-stage issue/handshake controller for an external multi-cycle multiplier.
// Optional one-entry result cache enabled by defining MUL_RESULT_CACHE_EN.
module mul_issue_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_m,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1_data,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic        flush,
  output logic [31:0] mul_rs1,
  output logic [31:0] mul_rs2,
  output logic [2:0]  mul_funct3,
  output logic        is_mul,
  input  logic        mul_done,
  input  logic [31:0] mul_out,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

`ifdef MUL_RESULT_CACHE_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE, HIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [WW-1:0] wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic        accept;
  logic        hit;

`ifdef MUL_RESULT_CACHE_EN
  logic        cache_v_q, cache_v_d;
  logic [2:0]  cache_f3_q, cache_f3_d;
  logic [31:0] cache_rs1_q, cache_rs1_d;
  logic [31:0] cache_rs2_q, cache_rs2_d;
  logic [31:0] cache_res_q, cache_res_d;

  assign hit = cache_v_q && (cache_f3_q == ex_funct3) &&
               (cache_rs1_q == ex_rs1_data) && (cache_rs2_q == ex_rs2_data);
`else
  assign hit = 1'b0;
`endif

  assign accept = ex_valid & ex_is_m & ~ex_funct3[2] & ~flush;

  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    stall     = 1'b0;
    is_mul    = 1'b0;
    wb_valid  = 1'b0;
`ifdef MUL_RESULT_CACHE_EN
    cache_v_d   = cache_v_q;
    cache_f3_d  = cache_f3_q;
    cache_rs1_d = cache_rs1_q;
    cache_rs2_d = cache_rs2_q;
    cache_res_d = cache_res_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
          rd_d  = ex_rd_addr;
          if (hit) begin
`ifdef MUL_RESULT_CACHE_EN
            wb_data_d = cache_res_q;
            state_d   = HIT;
`endif
          end else begin
            rs1_d    = ex_rs1_data;
            rs2_d    = ex_rs2_data;
            funct3_d = ex_funct3;
            wait_d   = '0;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        stall  = 1'b1;
        is_mul = 1'b1;
        // flush beats mul_done, which beats the timeout
        if (flush) begin
          state_d = IDLE;
        end else if (mul_done) begin
          wb_data_d = mul_out;
          state_d   = DONE;
        end else if (wait_q == WW'(MAX_WAIT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: begin
        wb_valid = ~flush;
        state_d  = IDLE;
`ifdef MUL_RESULT_CACHE_EN
        if (!flush) begin
          cache_v_d   = 1'b1;
          cache_f3_d  = funct3_q;
          cache_rs1_d = rs1_q;
          cache_rs2_d = rs2_q;
          cache_res_d = wb_data_q;
        end
`endif
      end
`ifdef MUL_RESULT_CACHE_EN
      HIT: begin
        wb_valid = ~flush;
        state_d  = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // handshake outputs stay quiet while reset is asserted
    if (rst) begin
      stall    = 1'b0;
      is_mul   = 1'b0;
      wb_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef MUL_RESULT_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_v_q   <= 1'b0;
      cache_f3_q  <= '0;
      cache_rs1_q <= '0;
      cache_rs2_q <= '0;
      cache_res_q <= '0;
    end else begin
      cache_v_q   <= cache_v_d;
      cache_f3_q  <= cache_f3_d;
      cache_rs1_q <= cache_rs1_d;
      cache_rs2_q <= cache_rs2_d;
      cache_res_q <= cache_res_d;
    end
  end
`endif

  assign mul_rs1     = rs1_q;
  assign mul_rs2     = rs2_q;
  assign mul_funct3  = funct3_q;
  assign wb_rd_addr  = rd_q;
  assign wb_data     = wb_data_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - randomized transaction-level check of mul_issue_ctrl.
module tb_mul_issue_ctrl;
  localparam int MW = 15;
`ifdef MUL_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_is_m, flush, mul_done;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1_data, ex_rs2_data, mul_out;
  logic [4:0]  ex_rd_addr;
  logic [31:0] mul_rs1, mul_rs2, wb_data;
  logic [2:0]  mul_funct3;
  logic        is_mul, stall, wb_valid, timeout_err;
  logic [4:0]  wb_rd_addr;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_m(ex_is_m), .ex_funct3(ex_funct3),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd_addr(ex_rd_addr),
    .flush(flush), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_funct3(mul_funct3),
    .is_mul(is_mul), .mul_done(mul_done), .mul_out(mul_out), .stall(stall),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  // expectations for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_is_mul, exp_wb, exp_to, exp_zero;
  logic [31:0] exp_rs1, exp_rs2, exp_data;
  logic [2:0]  exp_f3;
  logic [4:0]  exp_rd;

  // transaction-level model state
  bit          model_to = 1'b0;
  bit          c_v = 1'b0;
  logic [2:0]  c_f3;
  logic [31:0] c_rs1, c_rs2, c_res;
  logic [31:0] wb_seen[$];
  int          stall_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("is_mul", 32'(is_mul), 32'(exp_is_mul));
      chk("wb_valid", 32'(wb_valid), 32'(exp_wb));
      chk("timeout_err", 32'(timeout_err), 32'(exp_to));
      if (exp_wb) begin
        chk("wb_rd_addr", 32'(wb_rd_addr), 32'(exp_rd));
        chk("wb_data", wb_data, exp_data);
      end
      if (exp_is_mul) begin
        chk("mul_rs1", mul_rs1, exp_rs1);
        chk("mul_rs2", mul_rs2, exp_rs2);
        chk("mul_funct3", 32'(mul_funct3), 32'(exp_f3));
      end
      if (exp_zero) begin
        chk("rst_mul_rs1", mul_rs1, 32'd0);
        chk("rst_mul_rs2", mul_rs2, 32'd0);
        chk("rst_mul_funct3", 32'(mul_funct3), 32'd0);
        chk("rst_wb_rd_addr", 32'(wb_rd_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
      end
      if (wb_valid) wb_seen.push_back(wb_data);
      if (stall) stall_cycles++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst         = 1'b0;
    ex_valid    = 1'b0;
    ex_is_m     = 1'b0;
    ex_funct3   = 3'($urandom);
    ex_rs1_data = $urandom;
    ex_rs2_data = $urandom;
    ex_rd_addr  = 5'($urandom);
    flush       = 1'b0;
    mul_done    = 1'($urandom);
    mul_out     = $urandom;
    exp_stall   = 1'b0;
    exp_is_mul  = 1'b0;
    exp_wb      = 1'b0;
    exp_zero    = 1'b0;
    exp_to      = model_to;
    chk_en      = 1'b1;
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_m = 1'b1; ex_funct3 = f3;
    ex_rs1_data = a; ex_rs2_data = b; ex_rd_addr = rd;
  endtask

  task automatic busy_cycle(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
    next_cycle();
    present(f3, a, b, rd);
    mul_done = 1'b0;
    exp_stall = 1'b1; exp_is_mul = 1'b1;
    exp_rs1 = a; exp_rs2 = b; exp_f3 = f3;
  endtask

  task automatic accept_cycle(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd);
    next_cycle();
    present(f3, a, b, rd);
    exp_stall = 1'b1;
  endtask

  // full multiply: result arrives on BUSY cycle lat; optional flush during the writeback cycle
  task automatic do_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int lat,
                        input bit flush_wb);
    bit hit;
    hit = CACHE && c_v && c_f3 == f3 && c_rs1 == a && c_rs2 == b;
    accept_cycle(f3, a, b, rd);
    if (hit) begin
      next_cycle();
      present(f3, a, b, rd);
      flush = flush_wb;
      exp_wb = !flush_wb; exp_rd = rd; exp_data = c_res;
      return;
    end
    for (int k = 1; k <= lat; k++) begin
      busy_cycle(f3, a, b, rd);
      if (k == lat) begin
        mul_done = 1'b1;
        mul_out = res;
      end
    end
    next_cycle();
    present(f3, a, b, rd);
    flush = flush_wb;
    exp_wb = !flush_wb; exp_rd = rd; exp_data = res;
    if (!flush_wb) begin
      c_v = 1'b1; c_f3 = f3; c_rs1 = a; c_rs2 = b; c_res = res;
    end
  endtask

  task automatic do_flush_busy(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int k);
    accept_cycle(f3, a, b, rd);
    for (int i = 1; i <= k; i++) begin
      busy_cycle(f3, a, b, rd);
      if (i == k) begin
        flush = 1'b1;
        mul_done = 1'($urandom);
      end
    end
  endtask

  task automatic do_timeout(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
    accept_cycle(f3, a, b, rd);
    for (int i = 1; i <= MW; i++) busy_cycle(f3, a, b, rd);
    model_to = 1'b1;
  endtask

  task automatic do_reset_busy(input int k);
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    accept_cycle(3'd0, a, b, 5'd1);
    for (int i = 1; i <= k; i++) busy_cycle(3'd0, a, b, 5'd1);
    next_cycle();
    rst = 1'b1;
    model_to = 1'b0;
    c_v = 1'b0;
    next_cycle();
    exp_zero = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic settle();
    idle(1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n0;
    rst = 1'b1; ex_valid = 1'b0; ex_is_m = 1'b0; ex_funct3 = '0; ex_rs1_data = '0;
    ex_rs2_data = '0; ex_rd_addr = '0; flush = 1'b0; mul_done = 1'b0; mul_out = '0;
    exp_stall = 0; exp_is_mul = 0; exp_wb = 0; exp_to = 0; exp_zero = 0;
    repeat (2) @(posedge clk);
    next_cycle();
    exp_zero = 1'b1;

    // 7*6 with a 5-cycle multiplier
    settle();
    n0 = wb_seen.size();
    stall_cycles = 0;
    do_mul(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 5, 1'b0);
    settle();
    chk("mul7x6_stall_cycles", 32'(stall_cycles), 32'd6);
    chk("mul7x6_wb_count", 32'(wb_seen.size() - n0), 32'd1);
    chk("mul7x6_data", (wb_seen.size() > n0) ? wb_seen[n0] : 32'hx, 32'd42);

    n0 = wb_seen.size();
    do_mul(3'd1, 32'h8000_0000, 32'd2, 5'd9, 32'hFFFF_FFFF, 4, 1'b0);
    settle();
    chk("mulh_data", (wb_seen.size() > n0) ? wb_seen[n0] : 32'hx, 32'hFFFF_FFFF);

    n0 = wb_seen.size();
    do_flush_busy(3'd0, 32'd11, 32'd13, 5'd3, 2);
    do_mul(3'd0, 32'd11, 32'd13, 5'd3, 32'd143, 3, 1'b0);
    settle();
    chk("flush_then_op_wb_count", 32'(wb_seen.size() - n0), 32'd1);
    chk("flush_then_op_data", (wb_seen.size() > n0) ? wb_seen[n0] : 32'hx, 32'd143);

    n0 = wb_seen.size();
    do_timeout(3'd0, 32'd100, 32'd200, 5'd7);
    settle();
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_no_wb", 32'(wb_seen.size() - n0), 32'd0);
    do_reset_busy(3);

    n0 = wb_seen.size();
    do_mul(3'd0, 32'd3, 32'd4, 5'd1, 32'd12, 2, 1'b0);
    do_mul(3'd0, 32'd5, 32'd5, 5'd2, 32'd25, 3, 1'b0);
    settle();
    chk("b2b_wb_count", 32'(wb_seen.size() - n0), 32'd2);
    chk("b2b_first", (wb_seen.size() > n0) ? wb_seen[n0] : 32'hx, 32'd12);
    chk("b2b_second", (wb_seen.size() > n0 + 1) ? wb_seen[n0 + 1] : 32'hx, 32'd25);

    do_mul(3'd0, 32'd9, 32'd9, 5'd4, 32'd81, MW, 1'b0);
    do_mul(3'd2, 32'd9, 32'd8, 5'd4, 32'd72, 2, 1'b1);

`ifdef MUL_RESULT_CACHE_EN
    do_mul(3'd0, 32'd3, 32'd4, 5'd1, 32'd12, 2, 1'b0);
    do_mul(3'd0, 32'd3, 32'd4, 5'd6, 32'd12, 2, 1'b0);
    n0 = wb_seen.size();
    do_mul(3'd0, 32'd3, 32'd4, 5'd6, 32'd0, 2, 1'b0);
    settle();
    chk("hit_data", (wb_seen.size() > n0) ? wb_seen[n0] : 32'hx, 32'd12);
`endif

    for (int it = 0; it < 250; it++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          sel;
      f3 = 3'($urandom_range(0, 3));
      a = $urandom; b = $urandom; rd = 5'($urandom);
      sel = $urandom_range(0, 15);
      if (sel <= 6) do_mul(f3, a, b, rd, $urandom, $urandom_range(1, 6), 1'b0);
      else if (sel == 7) do_mul(f3, a, b, rd, $urandom, MW, 1'b0);
      else if (sel == 8) do_mul(f3, a, b, rd, $urandom, $urandom_range(1, 4), 1'b1);
      else if (sel == 9) do_flush_busy(f3, a, b, rd, $urandom_range(1, MW));
      else if (sel == 10) begin
        next_cycle();
        present(f3 | 3'd4, a, b, rd);
      end else if (sel == 11) begin
        next_cycle();
        present(f3, a, b, rd);
        ex_is_m = 1'b0;
      end else if (sel == 12) begin
        next_cycle();
        present(f3, a, b, rd);
        flush = 1'b1;
      end else if (sel == 13) idle($urandom_range(1, 3));
      else if (sel == 14 && $urandom_range(0, 5) == 0) do_timeout(f3, a, b, rd);
      else do_reset_busy($urandom_range(1, 5));
    end

    settle();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
